// File: rtl/phase_restorer.sv
// Receive-side phase restorer: re-aligns 128-bit blocks displaced by a SHIFT-bit header phase
// in the upper lane of each packet word, pairing each block with its source word's side field.
module phase_restorer #(
    parameter int unsigned LANE_W = 128,
    parameter int unsigned SIDE_W = 161,
    parameter int unsigned SHIFT  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LANE_W+SIDE_W-1:0]   i_text,
    input  logic                       i_first,
    input  logic                       i_last,
    input  logic                       i_valid,
    output logic                       i_ready,
    output logic [LANE_W-1:0]          o_block,
    output logic [SIDE_W-1:0]          o_side,
    output logic                       o_last,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic                       o_err
);

    localparam int unsigned WORD_W = LANE_W + SIDE_W;
    localparam int unsigned LOW_W  = LANE_W - SHIFT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LOW_W-1:0]    hold_low_q, hold_low_d;
    logic [SIDE_W-1:0]   hold_side_q, hold_side_d;
    logic [LANE_W-1:0]   block_d;
    logic [SIDE_W-1:0]   side_d;
    logic                last_d;
    logic                valid_d;
    logic                err_d;

    logic [LANE_W-1:0]   in_lane;
    logic [SIDE_W-1:0]   in_side;
    logic [LOW_W-1:0]    in_low;
    logic [SHIFT-1:0]    in_high;
    logic                out_free;
    logic                accept;
    logic                start_pkt;

    assign in_lane  = i_text[WORD_W-1:SIDE_W];
    assign in_side  = i_text[SIDE_W-1:0];
    assign in_low   = in_lane[LOW_W-1:0];
    assign in_high  = in_lane[LANE_W-1:LOW_W];

    // Output stage can take a block when empty or being drained this cycle.
    assign out_free = !o_valid || o_ready;
    assign i_ready  = (state_q != FLUSH) && out_free;
    assign accept   = i_valid && i_ready;

    // Next-state, held-word and output-stage logic.
    always_comb begin
        state_d     = state_q;
        hold_low_d  = hold_low_q;
        hold_side_d = hold_side_q;
        block_d     = o_block;
        side_d      = o_side;
        last_d      = o_last;
        valid_d     = o_valid && !o_ready;
        err_d       = 1'b0;
        start_pkt   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_first) begin
                        start_pkt = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (accept) begin
                    if (i_first) begin
                        // Missing last: held word is dropped, new word starts a packet.
                        err_d     = 1'b1;
                        start_pkt = 1'b1;
                    end else begin
                        block_d     = {hold_low_q, in_high};
                        side_d      = hold_side_q;
                        last_d      = 1'b0;
                        valid_d     = 1'b1;
                        hold_low_d  = in_low;
                        hold_side_d = in_side;
                        state_d     = i_last ? FLUSH : HOLD;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    block_d = {hold_low_q, SHIFT'(0)};
                    side_d  = hold_side_q;
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_pkt) begin
            if (i_last) begin
                block_d = {in_low, SHIFT'(0)};
                side_d  = in_side;
                last_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end else begin
                hold_low_d  = in_low;
                hold_side_d = in_side;
                state_d     = HOLD;
            end
        end
    end

    // State, held word and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_low_q  <= '0;
            hold_side_q <= '0;
            o_block     <= '0;
            o_side      <= '0;
            o_last      <= 1'b0;
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_low_q  <= hold_low_d;
            hold_side_q <= hold_side_d;
            o_block     <= block_d;
            o_side      <= side_d;
            o_last      <= last_d;
            o_valid     <= valid_d;
            o_err       <= err_d;
        end
    end

endmodule

// File: doc/phase_restorer.md
# phase_restorer

Receive-side counterpart of the transmit phase shifter in the AES-GCM datapath. Takes 289-bit packet words whose upper 128-bit lane carries cipher/payload data displaced by a 16-bit header phase, and restores 128-bit block alignment for GHASH and decrypt. It sits between the packet ingress word stream and the GCM block pipeline. It pairs each restored block with the side field of the word it came from, and flushes the tail block on packet end.

## Interface
Parameters:
- LANE_W, 128, payload lane width; block width
- SIDE_W, 161, pass-through side field width; word width = LANE_W+SIDE_W = 289
- SHIFT, 16, phase offset in bits; 0 < SHIFT < LANE_W

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- i_text  in  289  input word; lane L = i_text[288:161], side S = i_text[160:0]
- i_first  in  1  word is first of packet
- i_last  in  1  word is last of packet (may coincide with i_first)
- i_valid  in  1  input word valid
- i_ready  out  1  block accepts word when i_valid && i_ready
- o_block  out  128  restored aligned block
- o_side  out  161  side field of the word the block's upper bits came from
- o_last  out  1  block is packet tail
- o_valid  out  1  output valid
- o_ready  in  1  downstream accepts when o_valid && o_ready
- o_err  out  1  one-cycle pulse: protocol violation detected

## Operation
- Restoration rule: block k = {L_k[111:0], L_(k+1)[127:112]}, i.e. {L_k[LANE_W-SHIFT-1:0], L_(k+1)[LANE_W-1:LANE_W-SHIFT]}; o_side = S_k.
- Tail block = {L_last[111:0], 16'h0000}, o_last = 1, o_side = S_last.
- States:
  - IDLE: no lane held. Accepted word with i_first && i_last: emit its tail block, stay IDLE. Accepted word with i_first && !i_last: store L,S, go HOLD. Accepted word without i_first: discard, pulse o_err, stay IDLE.
  - HOLD: one word k held. Accepted word without i_first: emit block k using the new word's top 16 bits. If !i_last, store the new word and stay HOLD. If i_last, store it and go FLUSH.
  - HOLD, accepted word with i_first (missing last): discard the held word without emitting it, pulse o_err, then process the new word as in IDLE.
  - FLUSH: i_ready = 0. When the output register frees, load the tail block from the stored last word, go IDLE.
- Output register is a single stage. It loads only when empty or consumed in the same cycle.
- i_ready = (state != FLUSH) && (!o_valid || o_ready).
- A word that would emit is accepted only when the output stage can take the block. Non-emitting accepts (first word into IDLE) obey the same i_ready rule for simplicity.
- Reset values: state IDLE, o_valid 0, o_last 0, o_err 0, o_block 0, o_side 0, held registers 0. i_ready is 1 after reset.
- Reset mid-packet abandons held data silently: no o_err, no flush.

## Timing
- Outputs are registered. A block emitted by the word accepted at edge t is visible on o_* after edge t, and holds until o_valid && o_ready.
- Latency, first block of a multi-word packet: it appears one cycle after the second word is accepted.
- Latency, tail of a multi-word packet: the cycle after the last block is consumed. FLUSH lasts ≥1 cycle, so the fastest throughput is n+1 cycles for an n-word packet.
- Single-word packet: tail appears one cycle after accept.
- With o_ready held high and i_valid continuous, steady state is one block per cycle. One bubble cycle on i_ready per multi-word packet (FLUSH).
- o_valid stays asserted and o_block/o_side/o_last stay stable while o_ready is low.
- o_err asserts for exactly one cycle following the offending accept, independent of o_ready.

## Test plan
- Single word, L=0x0123…CDEF (128b), S=0x5A, first=last=1 -> one output: o_block = L[111:0]‖0x0000, o_side=0x5A, o_last=1, one cycle after accept.
- 3-word packet: L0=all 0x11, L1=all 0x22, L2=all 0x33 with o_ready=1 -> blocks 0x11…11‖0x2222, 0x22…22‖0x3333, 0x33…33‖0x0000 (last). i_ready is low for exactly one cycle after L2 is accepted.
- Same 3-word packet with o_ready low for 4 cycles after the first block -> o_block stays stable, i_ready=0, no words lost or duplicated, same three blocks produced.
- HOLD then a new i_first word without a prior i_last -> o_err pulses once. The held word produces no output; the new packet restores correctly.
- Word without i_first in IDLE -> o_err pulse, no o_valid, state remains IDLE.
- rst_n asserted in HOLD and in FLUSH -> o_valid=0 immediately (async), i_ready=1 after release. The next single-word packet is output correctly.
